regfile_multiport: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_rd_port.sv | 54 +++++
 rtl/regfile_multiport.sv | 102 ++++++++++
 tb/tb_regfile_multiport.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_pkg                                                  |
// | Description : Shared constants for the multiport register bank.           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package regfile_pkg;

    localparam int ST_W = 1;
    localparam logic [ST_W-1:0] ST_INIT = 1'b0;
    localparam logic [ST_W-1:0] ST_RUN  = 1'b1;

    localparam int MAX_RD = 4;

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_rd_port                                              |
// | Description : Registered read mux with write-first bypass, zero-register  |
// |               override and stall hold.                                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module regfile_rd_port #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rd_data
);

    logic              w_is_zero;
    logic              w_hit;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_data;

    assign w_is_zero = ZERO_REG && (rd_addr == '0);
    assign w_hit     = wr_en && (wr_addr == rd_addr);

    always_comb begin
        w_next = mem_data;
        if (w_is_zero) begin
            w_next = '0;
        end else if (w_hit) begin
            w_next = wr_data;
        end
    end

    // clr keeps the output at zero while the bank is being swept
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_data <= '0;
        end else if (rd_en) begin
            r_data <= w_next;
        end
    end

    assign rd_data = r_data;

endmodule
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_multiport                                            |
// | Description : Parametrised register bank, NUM_RD registered read ports,   |
// |               one write port, post-reset init sweep.                       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module regfile_multiport #(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 5,
    parameter int               NUM_RD   = 2,
    parameter bit               ZERO_REG = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     init_busy,
    output logic                     wr_dropped
);

    import regfile_pkg::*;

    localparam int              c_depth = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_last  = (ADDR_W + 1)'(c_depth - 1);

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [ST_W-1:0]   r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_wr_dropped;

    logic              w_in_init;
    logic              w_zero_hit;
    logic              w_wr_commit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_num_rd_check
        $error("regfile_multiport: NUM_RD must be within 1..MAX_RD");
    end

    assign w_in_init   = (r_state == ST_INIT);
    assign w_zero_hit  = ZERO_REG && (wr_addr == '0);
    assign w_wr_commit = wr_en && !w_in_init && !w_zero_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_wr_dropped <= 1'b0;
        end else begin
            r_wr_dropped <= wr_en && (w_in_init || w_zero_hit);
            if (w_in_init) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    // The sweep and normal writes share the single storage write port
    assign w_mem_we    = !rst && (w_in_init || w_wr_commit);
    assign w_mem_waddr = w_in_init ? r_cnt[ADDR_W-1:0] : wr_addr;
    assign w_mem_wdata = w_in_init ? INIT_VAL : wr_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .clr      (w_in_init),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
            .wr_en    (w_wr_commit),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .mem_data (r_mem[rd_addr[k*ADDR_W +: ADDR_W]]),
            .rd_data  (rd_data[k*DATA_W +: DATA_W])
        );
    end

    assign init_busy  = w_in_init;
    assign wr_dropped = r_wr_dropped;

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_multiport                                         |
// | Description : Randomised and directed bench for regfile_multiport against |
// |               an array-based reference model (ZERO_REG=1 and =0 copies).   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_regfile_multiport;

    localparam int          DW    = 32;
    localparam int          AW    = 5;
    localparam int          NR    = 2;
    localparam int          DEPTH = 32;
    localparam logic [31:0] IV    = 32'h0000_0004;

    logic               clk     = 1'b0;
    logic               rst     = 1'b1;
    logic               rd_en   = 1'b0;
    logic               wr_en   = 1'b0;
    logic [NR*AW-1:0]   rd_addr = '0;
    logic [AW-1:0]      wr_addr = '0;
    logic [DW-1:0]      wr_data = '0;

    logic [NR*DW-1:0]   rd_data_z, rd_data_n;
    logic               busy_z, busy_n, drop_z, drop_n;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    regfile_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .INIT_VAL(IV)
    ) dut_z (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_busy(busy_z), .wr_dropped(drop_z)
    );

    regfile_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b0), .INIT_VAL(IV)
    ) dut_n (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_busy(busy_n), .wr_dropped(drop_n)
    );

    // Reference model: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0
    logic [31:0] m_mem [2][DEPTH];
    logic [31:0] m_rd  [2][NR];
    bit          m_init [2];
    int          m_idx  [2];
    bit          m_drop [2];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit zr;
            zr = (i == 0);
            if (rst) begin
                m_valid   = 1'b1;
                m_init[i] = 1'b1;
                m_idx[i]  = 0;
                m_drop[i] = 1'b0;
                for (int k = 0; k < NR; k++) m_rd[i][k] = '0;
            end else if (m_init[i]) begin
                m_mem[i][m_idx[i]] = IV;
                m_idx[i]  = m_idx[i] + 1;
                m_drop[i] = wr_en;
                for (int k = 0; k < NR; k++) m_rd[i][k] = '0;
                if (m_idx[i] == DEPTH) m_init[i] = 1'b0;
            end else begin
                for (int k = 0; k < NR; k++) begin
                    if (rd_en) begin
                        int a;
                        a = int'(rd_addr[k*AW +: AW]);
                        if (zr && a == 0)                        m_rd[i][k] = '0;
                        else if (wr_en && int'(wr_addr) == a)    m_rd[i][k] = wr_data;
                        else                                     m_rd[i][k] = m_mem[i][a];
                    end
                end
                m_drop[i] = wr_en && zr && (wr_addr == '0);
                if (wr_en && !(zr && wr_addr == '0)) m_mem[i][int'(wr_addr)] = wr_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [NR*DW-1:0] rdv;
        for (int i = 0; i < 2; i++) begin
            rdv = (i == 0) ? rd_data_z : rd_data_n;
            for (int k = 0; k < NR; k++)
                chk($sformatf("rd_i%0d_p%0d", i, k), 64'(rdv[k*DW +: DW]), 64'(m_rd[i][k]));
            chk($sformatf("busy_i%0d", i), 64'((i == 0) ? busy_z : busy_n), 64'(m_init[i]));
            chk($sformatf("drop_i%0d", i), 64'((i == 0) ? drop_z : drop_n), 64'(m_drop[i]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (m_valid) compare_all();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    int n;

    initial begin
        // Reset sweep with random writes that must all be dropped
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n = 0;
        while (busy_z && n < 40) begin
            n++;
            wr_en   = $urandom_range(0, 1) == 1;
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            cyc();
        end
        chk("t1_busy_len", 64'(n), 64'(32));
        wr_en = 1'b0;
        rd_en = 1'b1;
        set_rd(5'd1, 5'd31);
        cyc();
        chk("t1_r1", 64'(rd_data_z[31:0]), 64'(32'h4));
        chk("t1_r31", 64'(rd_data_z[63:32]), 64'(32'h4));
        set_rd(5'd0, 5'd0);
        cyc();
        chk("t1_r0_zero", 64'(rd_data_z[31:0]), 64'(0));
        chk("t1_r0_nozero", 64'(rd_data_n[31:0]), 64'(32'h4));

        // Basic write then read
        wr(5'd5, 32'hDEAD_BEEF);
        cyc();
        wr_en = 1'b0;
        set_rd(5'd5, 5'd0);
        cyc();
        chk("t2_r5", 64'(rd_data_z[31:0]), 64'(32'hDEAD_BEEF));

        // Same-cycle bypass on both ports
        wr(5'd7, 32'h1234);
        set_rd(5'd7, 5'd7);
        cyc();
        wr_en = 1'b0;
        chk("t3_p0", 64'(rd_data_z[31:0]), 64'(32'h1234));
        chk("t3_p1", 64'(rd_data_z[63:32]), 64'(32'h1234));

        // Zero register
        wr(5'd0, 32'hFFFF_FFFF);
        set_rd(5'd0, 5'd0);
        cyc();
        wr_en = 1'b0;
        chk("t4_drop_z", 64'(drop_z), 64'(1));
        chk("t4_drop_n", 64'(drop_n), 64'(0));
        cyc();
        chk("t4_r0_z", 64'(rd_data_z[31:0]), 64'(0));
        chk("t4_r0_n", 64'(rd_data_n[31:0]), 64'(32'hFFFF_FFFF));
        chk("t4_drop_clr", 64'(drop_z), 64'(0));

        // Stall hold with writes during the stall
        wr(5'd3, 32'hA);
        set_rd(5'd3, 5'd1);
        cyc();
        chk("t5_first", 64'(rd_data_z[31:0]), 64'(32'hA));
        rd_en = 1'b0;
        wr(5'd3, 32'hB);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_hold", 64'(rd_data_z[31:0]), 64'(32'hA));
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        cyc();
        chk("t5_release", 64'(rd_data_z[31:0]), 64'(32'hB));

        // Reset mid-sweep
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        rst = 1'b1;
        cyc();
        chk("t6_rd_clr", 64'(rd_data_z), 64'(0));
        rst = 1'b0;
        wr(5'd9, 32'h55);
        n = 0;
        while (busy_z && n < 40) begin
            n++;
            cyc();
            if (n == 1) begin
                chk("t6_drop", 64'(drop_z), 64'(1));
                wr_en = 1'b0;
            end
        end
        chk("t6_busy_len", 64'(n), 64'(32));
        set_rd(5'd9, 5'd3);
        cyc();
        chk("t6_r9", 64'(rd_data_z[31:0]), 64'(32'h4));
        chk("t6_r3", 64'(rd_data_z[63:32]), 64'(32'h4));

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 249) == 0);
            rd_en   = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++)
                rd_addr[k*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            wr_data = $urandom;
            cyc();
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
`default_nettype wire
